aes_core_dec: RTL and testbench

- Iterative AES inverse-cipher (decryption) engine for 128/192/256-bit keys.
- An `init` pulse expands the supplied key into an internal round-key store, then raises `key_ready`.
- Each subsequent `next` pulse decrypts the 128-bit block `init_plain` into `plain`, one round per clock.
- Sits between the key/control logic and the data path. The usual system pulses `next` on the rising edge of `key_ready`.

---
 rtl/aes_core_dec.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_aes_core_dec.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_dec.sv
// ---------------------------------------------------------------------------
// aes_core_dec -- iterative AES inverse cipher (128/192/256-bit keys)
//
// An init pulse latches the key and expands it, one schedule word per clock,
// into an internal 60-word round-key store; key_ready then rises and stays
// high. Each next pulse decrypts init_plain, one round per clock, and raises
// decode_done for one cycle when plain is valid.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous reset, active HIGH (legacy name)
//   init         pulse: latch key_in/keylen and start key expansion
//   key_in[255:0] cipher key, MSB-aligned (128: [255:128], 192: [255:64])
//   keylen[1:0]  0=AES-128, 1=AES-192, 2=AES-256, 3=invalid
//   key_ready    round keys valid (level)
//   init_plain   ciphertext block, byte 0 = [127:120], sampled with next
//   next         pulse: start decrypting init_plain
//   plain        decrypted block, held until the next completion
//   decode_done  one-cycle pulse: plain valid
//   error        sticky error flag
//
// Build option: define AES_CORE_ERR_CHECK_EN to enable error reporting.
// Without it, error is constant 0, keylen=3 is decoded as AES-256 and a next
// without key_ready is silently dropped.
// ---------------------------------------------------------------------------

// One S-box lane: GF(2^8) inverse plus the affine map (or its inverse).
module aes_dec_sbox #(
   parameter bit INV = 1'b0
) (
   input  logic [7:0] din,
   output logic [7:0] dout
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 = x^-1 (0 maps to 0): product of x^2, x^4, ..., x^128
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] r;
      sq = x;
      r  = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] aff_fwd(input logic [7:0] x);
      return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
               ^ {x[3:0], x[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] aff_inv(input logic [7:0] y);
      return {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
   endfunction

   generate
      if (INV) begin : g_inv
         always_comb dout = gf_inv(aff_inv(din));
      end else begin : g_fwd
         always_comb dout = aff_fwd(gf_inv(din));
      end
   endgenerate

endmodule

module aes_core_dec (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         init,
   input  logic [255:0] key_in,
   input  logic [1:0]   keylen,
   output logic         key_ready,
   input  logic [127:0] init_plain,
   input  logic         next,
   output logic [127:0] plain,
   output logic         decode_done,
   output logic         error
);

`ifdef AES_CORE_ERR_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, KEXP, DEC} state_t;

   state_t       state_q, state_d;
   logic [1:0]   keylen_q, keylen_d;
   logic [31:0]  w_q [0:59];
   logic [31:0]  w_d [0:59];
   logic [5:0]   widx_q, widx_d;     // next schedule word to write
   logic [2:0]   kmod_q, kmod_d;     // widx mod Nk
   logic [7:0]   rcon_q, rcon_d;
   logic [127:0] blk_q, blk_d;       // cipher state
   logic [3:0]   rnd_q, rnd_d;       // round key index used this cycle
   logic [127:0] plain_q, plain_d;
   logic         done_q, done_d;
   logic         key_ready_q, key_ready_d;
   logic         error_q, error_d;

   function automatic logic [3:0] nk_of(input logic [1:0] kl);
      case (kl)
         2'd0:    return 4'd4;
         2'd1:    return 4'd6;
         default: return 4'd8;
      endcase
   endfunction

   function automatic logic [3:0] nr_of(input logic [1:0] kl);
      case (kl)
         2'd0:    return 4'd10;
         2'd1:    return 4'd12;
         default: return 4'd14;
      endcase
   endfunction

   function automatic logic [5:0] wtot_of(input logic [1:0] kl);
      case (kl)
         2'd0:    return 6'd44;
         2'd1:    return 6'd52;
         default: return 6'd60;
      endcase
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // ---------------- key length decode ----------------
   logic       klen_ok;
   logic [1:0] klen_in;
   logic [3:0] nk_in, nk, nr;
   logic [5:0] wtot;

   assign klen_ok = !ERR_EN || (keylen != 2'd3);
   assign klen_in = (keylen == 2'd3) ? 2'd2 : keylen;
   assign nk_in   = nk_of(klen_in);
   assign nk      = nk_of(keylen_q);
   assign nr      = nr_of(keylen_q);
   assign wtot    = wtot_of(keylen_q);

   // ---------------- key schedule datapath ----------------
   logic [31:0] prev_w, back_w, sub_in, sub_out, temp_w;

   assign prev_w = w_q[widx_q - 6'd1];
   assign back_w = w_q[widx_q - {2'b00, nk}];
   assign sub_in = (kmod_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

   generate
      for (genvar b = 0; b < 4; b++) begin : g_ksb
         aes_dec_sbox #(.INV(1'b0)) u_sb (
            .din  (sub_in[8*b +: 8]),
            .dout (sub_out[8*b +: 8])
         );
      end
   endgenerate

   always_comb begin
      temp_w = prev_w;
      if (kmod_q == 3'd0)
         temp_w = sub_out ^ {rcon_q, 24'h0};
      else if (nk == 4'd8 && kmod_q == 3'd4)
         temp_w = sub_out;
   end

   // ---------------- round datapath ----------------
   logic [127:0] rk, isr, isb, ark, imc;

   assign rk = {w_q[{rnd_q, 2'b00}], w_q[{rnd_q, 2'b01}],
                w_q[{rnd_q, 2'b10}], w_q[{rnd_q, 2'b11}]};

   // byte n of a block lives at [8*(15-n) +: 8]; column c holds bytes 4c..4c+3
   generate
      for (genvar c = 0; c < 4; c++) begin : g_col
         for (genvar r = 0; r < 4; r++) begin : g_row
            // InvShiftRows: row r rotates right by r columns
            assign isr[8*(15-(4*c+r)) +: 8] = blk_q[8*(15-(4*((c+4-r)%4)+r)) +: 8];
            aes_dec_sbox #(.INV(1'b1)) u_isb (
               .din  (isr[8*(15-(4*c+r)) +: 8]),
               .dout (isb[8*(15-(4*c+r)) +: 8])
            );
         end
         logic [7:0] a0, a1, a2, a3;
         assign a0 = ark[8*(15-4*c) +: 8];
         assign a1 = ark[8*(14-4*c) +: 8];
         assign a2 = ark[8*(13-4*c) +: 8];
         assign a3 = ark[8*(12-4*c) +: 8];
         assign imc[8*(15-4*c) +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         assign imc[8*(14-4*c) +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         assign imc[8*(13-4*c) +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         assign imc[8*(12-4*c) +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
   endgenerate

   assign ark = isb ^ rk;

   // ---------------- next state ----------------
   always_comb begin
      state_d     = state_q;
      keylen_d    = keylen_q;
      w_d         = w_q;
      widx_d      = widx_q;
      kmod_d      = kmod_q;
      rcon_d      = rcon_q;
      blk_d       = blk_q;
      rnd_d       = rnd_q;
      plain_d     = plain_q;
      done_d      = 1'b0;
      key_ready_d = key_ready_q;
      error_d     = error_q;

      case (state_q)
         IDLE, KEXP: begin
            if (init) begin
               // init takes priority over next and restarts any expansion
               if (klen_ok) begin
                  keylen_d = klen_in;
                  for (int j = 0; j < 8; j++)
                     if (j < int'(nk_in)) w_d[j] = key_in[32*(7-j) +: 32];
                  widx_d      = {2'b00, nk_in};
                  kmod_d      = 3'd0;
                  rcon_d      = 8'h01;
                  key_ready_d = 1'b0;
                  error_d     = 1'b0;
                  state_d     = KEXP;
               end else begin
                  error_d     = 1'b1;
                  key_ready_d = 1'b0;
                  state_d     = IDLE;
               end
            end else if (state_q == IDLE) begin
               if (next) begin
                  if (key_ready_q) begin
                     blk_d   = init_plain;
                     rnd_d   = nr;
                     state_d = DEC;
                  end else if (ERR_EN) begin
                     error_d = 1'b1;
                  end
               end
            end else begin
               if (next && ERR_EN) error_d = 1'b1;
               // one idle step after the last word gives the W-Nk+1 edge timing
               if (widx_q == wtot) begin
                  key_ready_d = 1'b1;
                  state_d     = IDLE;
               end else begin
                  w_d[widx_q] = back_w ^ temp_w;
                  widx_d      = widx_q + 6'd1;
                  kmod_d      = ({1'b0, kmod_q} == nk - 4'd1) ? 3'd0 : kmod_q + 3'd1;
                  if (kmod_q == 3'd0)
                     rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
               end
            end
         end
         DEC: begin
            if (rnd_q == nr) begin
               blk_d = blk_q ^ rk;
               rnd_d = rnd_q - 4'd1;
            end else if (rnd_q != 4'd0) begin
               blk_d = imc;
               rnd_d = rnd_q - 4'd1;
            end else begin
               plain_d = ark;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q     <= IDLE;
         keylen_q    <= 2'd0;
         widx_q      <= 6'd0;
         kmod_q      <= 3'd0;
         rcon_q      <= 8'h01;
         blk_q       <= '0;
         rnd_q       <= 4'd0;
         plain_q     <= '0;
         done_q      <= 1'b0;
         key_ready_q <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         keylen_q    <= keylen_d;
         widx_q      <= widx_d;
         kmod_q      <= kmod_d;
         rcon_q      <= rcon_d;
         blk_q       <= blk_d;
         rnd_q       <= rnd_d;
         plain_q     <= plain_d;
         done_q      <= done_d;
         key_ready_q <= key_ready_d;
         error_q     <= error_d;
      end
   end

   // round-key store needs no reset: key_ready gates every use
   always_ff @(posedge clk) begin
      w_q <= w_d;
   end

   assign key_ready   = key_ready_q;
   assign plain       = plain_q;
   assign decode_done = done_q;
   assign error       = error_q;

endmodule

// File: tb/tb_aes_core_dec.sv
// ---------------------------------------------------------------------------
// tb_aes_core_dec -- self-checking bench for aes_core_dec
// FIPS-197 C.1/C.2/C.3 vectors in a table; expected plaintexts go into a
// scoreboard queue when next is driven and are popped on decode_done.
// ---------------------------------------------------------------------------
module tb_aes_core_dec;

`ifdef AES_CORE_ERR_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         init = 1'b0;
   logic [255:0] key_in = '0;
   logic [1:0]   keylen = 2'd0;
   logic         key_ready;
   logic [127:0] init_plain = '0;
   logic         next = 1'b0;
   logic [127:0] plain;
   logic         decode_done;
   logic         error;

   int errors = 0;
   int checks = 0;
   logic [127:0] sb_q [$];

   aes_core_dec dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .init        (init),
      .key_in      (key_in),
      .keylen      (keylen),
      .key_ready   (key_ready),
      .init_plain  (init_plain),
      .next        (next),
      .plain       (plain),
      .decode_done (decode_done),
      .error       (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   kl;
      logic [255:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
      int           kr_edges;
      int           done_edges;
   } vec_t;

   vec_t vecs [3];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // scoreboard monitor
   initial begin
      logic [127:0] exp;
      forever begin
         tick();
         if (decode_done === 1'b1) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected_done: plain=%h with nothing pending", plain);
            end else begin
               exp = sb_q.pop_front();
               chk("sb_plain", plain, exp);
            end
         end
      end
   end

   task automatic do_init(input logic [1:0] kl, input logic [255:0] key,
                          input int exp_edges, input bit poke_next);
      int n;
      init = 1'b1; keylen = kl; key_in = key;
      tick();
      init = 1'b0;
      chk("init_kr_clear", {127'b0, key_ready}, 128'd0);
      chk("init_err_clear", {127'b0, error}, 128'd0);
      if (poke_next) next = 1'b1;
      n = 0;
      while (n < 100) begin
         tick();
         n++;
         if (n == 1 && poke_next) begin
            next = 1'b0;
            chk("kexp_next_err", {127'b0, error}, {127'b0, ERR_EN});
         end
         if (key_ready === 1'b1) break;
      end
      chk("kr_edges", 128'(n), 128'(exp_edges));
   endtask

   task automatic do_next(input logic [127:0] ct, input logic [127:0] pt, input int exp_edges);
      int n;
      bit kr_drop;
      next = 1'b1; init_plain = ct;
      sb_q.push_back(pt);
      tick();
      next = 1'b0;
      init_plain = ~ct;   // must not matter after sampling
      n = 0; kr_drop = 1'b0;
      while (n < 40) begin
         tick();
         n++;
         if (key_ready !== 1'b1) kr_drop = 1'b1;
         if (decode_done === 1'b1) break;
      end
      chk("done_edges", 128'(n), 128'(exp_edges));
      chk("kr_held", {127'b0, kr_drop}, 128'd0);
      tick();
      chk("done_pulse_width", {127'b0, decode_done}, 128'd0);
      chk("plain_hold", plain, pt);
   endtask

   initial begin
      vecs[0] = '{kl: 2'd0,
                  key: {128'h000102030405060708090a0b0c0d0e0f, 128'hdeadbeefcafef00d0123456789abcdef},
                  ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  pt: 128'h00112233445566778899aabbccddeeff, kr_edges: 41, done_edges: 11};
      vecs[1] = '{kl: 2'd1,
                  key: {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h5a5a5a5aa5a5a5a5},
                  ct: 128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                  pt: 128'h00112233445566778899aabbccddeeff, kr_edges: 47, done_edges: 13};
      vecs[2] = '{kl: 2'd2,
                  key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  ct: 128'h8ea2b7ca516745bfeafc49904b496089,
                  pt: 128'h00112233445566778899aabbccddeeff, kr_edges: 53, done_edges: 15};

      // reset state
      repeat (3) tick();
      chk("rst_key_ready", {127'b0, key_ready}, 128'd0);
      chk("rst_done", {127'b0, decode_done}, 128'd0);
      chk("rst_error", {127'b0, error}, 128'd0);
      chk("rst_plain", plain, 128'd0);
      rst_n = 1'b0;
      tick();

      // FIPS-197 vectors; the AES-128 one also runs back-to-back blocks
      for (int v = 0; v < 3; v++) begin
         do_init(vecs[v].kl, vecs[v].key, vecs[v].kr_edges, 1'b0);
         do_next(vecs[v].ct, vecs[v].pt, vecs[v].done_edges);
         if (v == 0) begin
            do_next(vecs[v].ct, vecs[v].pt, vecs[v].done_edges);
            chk("b2b_kr", {127'b0, key_ready}, 128'd1);
         end
      end

      // next with no key
      rst_n = 1'b1; tick(); rst_n = 1'b0; tick();
      next = 1'b1; init_plain = vecs[0].ct;
      tick();
      next = 1'b0;
      chk("next_nokey_err", {127'b0, error}, {127'b0, ERR_EN});
      repeat (20) tick();
      chk("next_nokey_kr", {127'b0, key_ready}, 128'd0);

      // valid init clears error; next during expansion
      do_init(2'd0, vecs[0].key, 41, 1'b1);
      do_init(2'd0, vecs[0].key, 41, 1'b0);
      do_next(vecs[0].ct, vecs[0].pt, 11);

      // keylen = 3
`ifdef AES_CORE_ERR_CHECK_EN
      init = 1'b1; keylen = 2'd3; key_in = vecs[2].key;
      tick();
      init = 1'b0;
      chk("klen3_err", {127'b0, error}, 128'd1);
      chk("klen3_kr", {127'b0, key_ready}, 128'd0);
      repeat (60) tick();
      chk("klen3_kr_stays", {127'b0, key_ready}, 128'd0);
`else
      do_init(2'd3, vecs[2].key, 53, 1'b0);
      do_next(vecs[2].ct, vecs[2].pt, 15);
      chk("klen3_err", {127'b0, error}, 128'd0);
`endif

      // reset in the middle of a decryption
      do_init(2'd0, vecs[0].key, 41, 1'b0);
      do_next(vecs[0].ct, vecs[0].pt, 11);
      next = 1'b1; init_plain = vecs[0].ct;
      sb_q.push_back(vecs[0].pt);
      tick();
      next = 1'b0;
      repeat (4) tick();
      rst_n = 1'b1;
      #1;
      chk("midrst_plain", plain, 128'd0);
      chk("midrst_done", {127'b0, decode_done}, 128'd0);
      chk("midrst_kr", {127'b0, key_ready}, 128'd0);
      chk("midrst_err", {127'b0, error}, 128'd0);
      sb_q.delete();
      #2 rst_n = 1'b0;
      repeat (20) tick();
      chk("postrst_kr", {127'b0, key_ready}, 128'd0);
      chk("postrst_plain", plain, 128'd0);

      chk("sb_drained", 128'(sb_q.size()), 128'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
